// File: rtl/layers_ctrl.sv
// Layer-pass sequencer: writes the layer config word, gates the image stream and counts results.
// Optional result watchdog in DRAIN is enabled with `define LAYERS_CTRL_TIMEOUT_EN.
module layers_ctrl #(
  parameter int unsigned CFG_DWIDTH  = 32,
  parameter int unsigned CFG_AWIDTH  = 5,
  parameter int unsigned CFG_ADDR    = 0,
  parameter int unsigned COUNT_WIDTH = 16,
  parameter int unsigned SHIFT_MAX   = 17,
  parameter int unsigned POOL_MAX    = 4,
  parameter int unsigned TIMEOUT     = 1024,
  parameter int unsigned SRC_WIDTH   = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             cmd_shift,
  input  logic [7:0]             cmd_pool,
  input  logic                   cmd_relu,
  input  logic [COUNT_WIDTH-1:0] cmd_img_len,
  input  logic [COUNT_WIDTH-1:0] cmd_res_len,
  input  logic                   cmd_val,
  output logic                   cmd_rdy,
  output logic [CFG_DWIDTH-1:0]  cfg_data,
  output logic [CFG_AWIDTH-1:0]  cfg_addr,
  output logic                   cfg_valid,
  input  logic                   kernel_rdy,
  input  logic [SRC_WIDTH-1:0]   src_bus,
  input  logic                   src_val,
  output logic                   src_rdy,
  output logic                   image_val,
  input  logic                   image_rdy,
  output logic                   image_last,
  input  logic                   result_val,
  input  logic                   result_rdy,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  typedef enum logic [2:0] {
    StIdle,
    StCfg,
    StWaitKer,
    StStream,
    StDrain,
    StDone
  } state_e;

  localparam logic [7:0]             ShiftMax = 8'(SHIFT_MAX);
  localparam logic [7:0]             PoolMax  = 8'(POOL_MAX);
  localparam logic [CFG_AWIDTH-1:0]  CfgAddr  = CFG_AWIDTH'(CFG_ADDR);
  localparam logic [COUNT_WIDTH-1:0] CntOne   = COUNT_WIDTH'(1);

  state_e                 state_q, state_d;
  logic [COUNT_WIDTH-1:0] img_len_q, img_len_d;
  logic [COUNT_WIDTH-1:0] res_len_q, res_len_d;
  logic [COUNT_WIDTH-1:0] img_cnt_q, img_cnt_d;
  logic [COUNT_WIDTH-1:0] res_cnt_q, res_cnt_d;
  logic                   cmd_rdy_q, cmd_rdy_d;
  logic                   cfg_valid_q, cfg_valid_d;
  logic [CFG_DWIDTH-1:0]  cfg_data_q, cfg_data_d;
  logic [CFG_AWIDTH-1:0]  cfg_addr_q, cfg_addr_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;

  logic                   cmd_accept;
  logic                   cmd_bad;
  logic                   in_stream;
  logic                   last_beat;
  logic                   image_hs;
  logic                   result_hs;
  logic                   res_count_en;
  logic [CFG_DWIDTH-1:0]  cfg_word;

  // The image source bus bypasses this block entirely.
  logic unused_src_bus;
  assign unused_src_bus = ^src_bus;

`ifdef LAYERS_CTRL_TIMEOUT_EN
  localparam int unsigned       WdWidth = $clog2(TIMEOUT + 1);
  localparam logic [WdWidth-1:0] WdLast = WdWidth'(TIMEOUT - 1);
  localparam logic [WdWidth-1:0] WdOne  = WdWidth'(1);

  logic [WdWidth-1:0] wd_q, wd_d;
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = TIMEOUT;
`endif

  assign cmd_accept = (state_q == StIdle) && cmd_val && cmd_rdy_q;
  assign cmd_bad    = (cmd_shift > ShiftMax) || (cmd_pool > PoolMax) ||
                      (cmd_img_len == '0) || (cmd_res_len == '0);

  // Image path is combinational so the gate adds no latency.
  assign in_stream  = (state_q == StStream);
  assign last_beat  = (img_cnt_q == img_len_q - CntOne);
  assign image_val  = in_stream & src_val;
  assign src_rdy    = in_stream & image_rdy;
  assign image_last = in_stream & last_beat;
  assign image_hs   = image_val & image_rdy;

  assign result_hs    = result_val & result_rdy;
  assign res_count_en = ((state_q == StStream) || (state_q == StDrain)) && result_hs &&
                        (res_cnt_q < res_len_q);

  always_comb begin
    cfg_word        = '0;
    cfg_word[7:0]   = cmd_shift;
    cfg_word[15:8]  = cmd_pool;
    cfg_word[16]    = cmd_relu;
  end

  always_comb begin
    state_d    = state_q;
    img_len_d  = img_len_q;
    res_len_d  = res_len_q;
    cfg_data_d = cfg_data_q;
    cfg_addr_d = cfg_addr_q;
    err_d      = 1'b0;
    img_cnt_d  = img_cnt_q;
    res_cnt_d  = res_cnt_q;
`ifdef LAYERS_CTRL_TIMEOUT_EN
    wd_d       = '0;
    if ((state_q == StDrain) && !result_hs) begin
      wd_d = wd_q + WdOne;
    end
`endif

    if (in_stream && image_hs) begin
      img_cnt_d = img_cnt_q + CntOne;
    end
    if (res_count_en) begin
      res_cnt_d = res_cnt_q + CntOne;
    end

    unique case (state_q)
      StIdle: begin
        if (cmd_accept) begin
          img_len_d = cmd_img_len;
          res_len_d = cmd_res_len;
          if (cmd_bad) begin
            err_d = 1'b1;
          end else begin
            state_d    = StCfg;
            cfg_data_d = cfg_word;
            cfg_addr_d = CfgAddr;
          end
        end
      end
      StCfg: begin
        state_d = StWaitKer;
      end
      StWaitKer: begin
        if (kernel_rdy) begin
          state_d = StStream;
        end
      end
      StStream: begin
        if (image_hs && last_beat) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        // Looking at the next count lets the final result reach done in one cycle.
        if (res_cnt_d == res_len_q) begin
          state_d = StDone;
`ifdef LAYERS_CTRL_TIMEOUT_EN
        end else if (!result_hs && (wd_q == WdLast)) begin
          state_d   = StIdle;
          err_d     = 1'b1;
          img_cnt_d = '0;
          res_cnt_d = '0;
`endif
        end
      end
      StDone: begin
        state_d   = StIdle;
        img_cnt_d = '0;
        res_cnt_d = '0;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // cmd_rdy drops for the err cycle so a rejected command is never double-sampled.
    cmd_rdy_d   = (state_d == StIdle) && !err_d;
    cfg_valid_d = (state_d == StCfg);
    busy_d      = (state_d != StIdle);
    done_d      = (state_d == StDone);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      img_len_q   <= '0;
      res_len_q   <= '0;
      img_cnt_q   <= '0;
      res_cnt_q   <= '0;
      cmd_rdy_q   <= 1'b0;
      cfg_valid_q <= 1'b0;
      cfg_data_q  <= '0;
      cfg_addr_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      img_len_q   <= img_len_d;
      res_len_q   <= res_len_d;
      img_cnt_q   <= img_cnt_d;
      res_cnt_q   <= res_cnt_d;
      cmd_rdy_q   <= cmd_rdy_d;
      cfg_valid_q <= cfg_valid_d;
      cfg_data_q  <= cfg_data_d;
      cfg_addr_q  <= cfg_addr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

`ifdef LAYERS_CTRL_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_d;
    end
  end
`endif

  assign cmd_rdy   = cmd_rdy_q;
  assign cfg_valid = cfg_valid_q;
  assign cfg_data  = cfg_data_q;
  assign cfg_addr  = cfg_addr_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

`ifndef SYNTHESIS
  a_cfg_single: assert property (@(posedge clk) disable iff (rst) cfg_valid |=> !cfg_valid);
  a_done_err:   assert property (@(posedge clk) disable iff (rst) !(done && err));
  a_img_bound:  assert property (@(posedge clk) disable iff (rst) img_cnt_q <= img_len_q);
  a_res_bound:  assert property (@(posedge clk) disable iff (rst) res_cnt_q <= res_len_q);
  a_last_hold:  assert property (@(posedge clk) disable iff (rst)
                                 (image_val && !image_rdy) |=> (image_last == $past(image_last)));
`endif

endmodule

// File: tb/tb_layers_ctrl.sv
// Bench for layers_ctrl: vector table of passes, randomized passes against a transaction model,
// plus reset-mid-stream and (with LAYERS_CTRL_TIMEOUT_EN) watchdog sequences.
module tb_layers_ctrl;

  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    cmd_shift, cmd_pool;
  logic          cmd_relu;
  logic [CW-1:0] cmd_img_len, cmd_res_len;
  logic          cmd_val, cmd_rdy;
  logic [31:0]   cfg_data;
  logic [4:0]    cfg_addr;
  logic          cfg_valid, kernel_rdy;
  logic [31:0]   src_bus;
  logic          src_val, src_rdy, image_val, image_rdy, image_last;
  logic          result_val, result_rdy, busy, done, err;

  int checks = 0;
  int errors = 0;

  layers_ctrl #(
    .TIMEOUT(16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_shift  (cmd_shift),
    .cmd_pool   (cmd_pool),
    .cmd_relu   (cmd_relu),
    .cmd_img_len(cmd_img_len),
    .cmd_res_len(cmd_res_len),
    .cmd_val    (cmd_val),
    .cmd_rdy    (cmd_rdy),
    .cfg_data   (cfg_data),
    .cfg_addr   (cfg_addr),
    .cfg_valid  (cfg_valid),
    .kernel_rdy (kernel_rdy),
    .src_bus    (src_bus),
    .src_val    (src_val),
    .src_rdy    (src_rdy),
    .image_val  (image_val),
    .image_rdy  (image_rdy),
    .image_last (image_last),
    .result_val (result_val),
    .result_rdy (result_rdy),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          shift;
    int          pool;
    int          relu;
    int          img_len;
    int          res_len;
    int          kdelay;     // cycles kernel_rdy stays low after cfg
    int          mode;       // 0 all ready, 1 random, 2 image_rdy pattern 1,0,0
    int          res_start;  // first cycle results are offered (modes 0/2)
    bit          exp_reject;
    logic [31:0] exp_cfg;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit ref_reject(input vec_t v);
    return (v.shift > 17) || (v.pool > 4) || (v.img_len == 0) || (v.res_len == 0);
  endfunction

  function automatic logic [31:0] ref_cfg(input vec_t v);
    return 32'(v.shift + v.pool * 256 + v.relu * 65536);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    kernel_rdy = 0; src_val = 0; image_rdy = 0; result_val = 0; result_rdy = 0; cmd_val = 0;
  endtask

  // One full command: j indexes the sample point after edge A+j, A being the accept edge.
  task automatic run_pass(input vec_t v);
    int waitc = 0;
    int d = v.kdelay;
    int lst = -1, rch = -1, dn = -1;
    int img_hs = 0, res_hs = 0, act_hs = 0, act_last = 0;
    int j;
    bit open_exp;
    idle_inputs();
    while (cmd_rdy !== 1'b1 && waitc < 20) begin
      step();
      waitc++;
    end
    check("cmd_rdy_before_cmd", cmd_rdy, 1);
    cmd_shift   = 8'(v.shift);
    cmd_pool    = 8'(v.pool);
    cmd_relu    = v.relu[0];
    cmd_img_len = CW'(v.img_len);
    cmd_res_len = CW'(v.res_len);
    cmd_val     = 1;
    @(posedge clk);
    #1 cmd_val = 0;
    #1;
    check("err_after_cmd", err, v.exp_reject);
    check("cfg_valid_after_cmd", cfg_valid, !v.exp_reject);
    check("busy_after_cmd", busy, !v.exp_reject);
    check("cmd_rdy_after_cmd", cmd_rdy, 0);
    if (v.exp_reject) begin
      step();
      check("cmd_rdy_after_err", cmd_rdy, 1);
      check("err_single", err, 0);
      check("cfg_valid_on_reject", cfg_valid, 0);
      return;
    end
    check("cfg_data", cfg_data, v.exp_cfg);
    check("cfg_addr", cfg_addr, 0);
    for (j = 0; j < 600; j++) begin
      if (j > 0) @(posedge clk);
      #1;
      open_exp   = (j >= 2 + d) && (img_hs < v.img_len);
      kernel_rdy = (j >= 1 + d);
      src_bus    = $urandom;
      if (v.mode == 1) begin
        src_val    = ($urandom_range(0, 3) != 0);
        image_rdy  = ($urandom_range(0, 3) != 0);
        result_val = ($urandom_range(0, 3) != 0);
        result_rdy = ($urandom_range(0, 3) != 0);
      end else begin
        src_val    = 1;
        image_rdy  = (v.mode == 2 && j >= 2 + d) ? ((j - 2 - d) % 3 == 0) : 1'b1;
        result_val = (j >= v.res_start);
        result_rdy = result_val;
      end
      #1;
      if (lst >= 0 && rch >= 0) dn = (lst + 1 > rch) ? lst + 1 : rch;
      if (dn >= 0 && j == dn + 1) begin
        check("done_single", done, 0);
        check("busy_idle", busy, 0);
        check("cmd_rdy_after_done", cmd_rdy, 1);
        break;
      end
      if (j > 0) check("cfg_valid_one_cycle", cfg_valid, 0);
      check("image_val", image_val, open_exp & src_val);
      check("src_rdy", src_rdy, open_exp & image_rdy);
      check("image_last", image_last, open_exp && (img_hs == v.img_len - 1));
      check("done", done, (dn >= 0) && (j == dn));
      check("busy", busy, 1);
      check("err_in_pass", err, 0);
      if (image_val && image_rdy) begin
        act_hs++;
        if (image_last) act_last++;
      end
      if (open_exp && src_val && image_rdy) begin
        img_hs++;
        if (img_hs == v.img_len) lst = j + 1;
      end
      if (j >= 2 + d && result_val && result_rdy && res_hs < v.res_len) begin
        res_hs++;
        if (res_hs == v.res_len) rch = j + 1;
      end
    end
    check("pass_completed", (dn >= 0) && (j == dn + 1), 1);
    check("image_handshakes", act_hs, v.img_len);
    check("image_last_beats", act_last, 1);
    idle_inputs();
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    vec_t rv;
    //            sh pl rl img res kd md rs rej cfg
    vecs.push_back('{8,  2, 1, 4, 2, 0,  0, 7, 1'b0, 32'h0001_0208});
    vecs.push_back('{18, 2, 1, 4, 2, 0,  0, 0, 1'b1, 32'h0});
    vecs.push_back('{8,  2, 1, 0, 2, 0,  0, 0, 1'b1, 32'h0});
    vecs.push_back('{3,  5, 0, 4, 2, 0,  0, 0, 1'b1, 32'h0});
    vecs.push_back('{3,  1, 0, 4, 0, 0,  0, 0, 1'b1, 32'h0});
    vecs.push_back('{17, 4, 0, 1, 1, 0,  0, 0, 1'b0, 32'h0000_0411});
    vecs.push_back('{0,  0, 1, 3, 1, 0,  2, 0, 1'b0, 32'h0001_0000});
    vecs.push_back('{5,  1, 0, 2, 3, 10, 0, 0, 1'b0, 32'h0000_0105});

    // Reset state, with the image path inputs asserted to prove the gating.
    rst = 1;
    idle_inputs();
    src_val = 1; image_rdy = 1; src_bus = '0;
    cmd_shift = 0; cmd_pool = 0; cmd_relu = 0; cmd_img_len = 0; cmd_res_len = 0;
    #3;
    check("rst_cmd_rdy", cmd_rdy, 0);
    check("rst_cfg_valid", cfg_valid, 0);
    check("rst_cfg_data", cfg_data, 0);
    check("rst_cfg_addr", cfg_addr, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_image_val", image_val, 0);
    check("rst_src_rdy", src_rdy, 0);
    repeat (2) @(posedge clk);
    #2 rst = 0;
    idle_inputs();
    #1 check("cmd_rdy_before_first_edge", cmd_rdy, 0);
    step();
    check("cmd_rdy_after_reset", cmd_rdy, 1);

    foreach (vecs[i]) run_pass(vecs[i]);

    // Reset in the middle of STREAM after 2 of 4 beats.
    cmd_shift = 8; cmd_pool = 2; cmd_relu = 1; cmd_img_len = 4; cmd_res_len = 2;
    kernel_rdy = 1; src_val = 1; image_rdy = 1; cmd_val = 1;
    @(posedge clk);
    #1 cmd_val = 0;
    repeat (4) step();
    #1;
    check("pre_rst_image_val", image_val, 1);
    check("pre_rst_busy", busy, 1);
    rst = 1;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_image_val", image_val, 0);
    check("mid_rst_src_rdy", src_rdy, 0);
    check("mid_rst_cmd_rdy", cmd_rdy, 0);
    step();
    rst = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("no_done_after_rst", done, 0);
    end
    run_pass(vecs[0]);

`ifdef LAYERS_CTRL_TIMEOUT_EN
    // No results at all: DRAIN entered after edge A+4, abort 16 cycles later.
    idle_inputs();
    cmd_shift = 1; cmd_pool = 1; cmd_relu = 0; cmd_img_len = 2; cmd_res_len = 1;
    kernel_rdy = 1; src_val = 1; image_rdy = 1; cmd_val = 1;
    @(posedge clk);
    #1 cmd_val = 0;
    for (int k = 1; k <= 21; k++) begin
      step();
      check("timeout_done", done, 0);
      check("timeout_err", err, k == 20);
      if (k == 20) check("timeout_busy", busy, 0);
      if (k == 21) check("timeout_cmd_rdy", cmd_rdy, 1);
    end
    idle_inputs();
`endif

    for (int n = 0; n < 40; n++) begin
      rv.shift      = $urandom_range(0, 19);
      rv.pool       = $urandom_range(0, 5);
      rv.relu       = $urandom_range(0, 1);
      rv.img_len    = $urandom_range(0, 6);
      rv.res_len    = $urandom_range(0, 5);
      rv.kdelay     = $urandom_range(0, 4);
      rv.mode       = 1;
      rv.res_start  = 0;
      rv.exp_reject = ref_reject(rv);
      rv.exp_cfg    = ref_cfg(rv);
      run_pass(rv);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
